sram_access_arbiter: RTL

- Shares the single 32-bit SRAM controller word interface (rd_en/wr_en/address/write_data → read_data/ready) between two requesters: port 0 is the MEM-stage data access, port 1 is a secondary master (instruction prefetch or debug/DMA loader).
- Selects one request, latches its command and holds it stable on the controller interface until the controller pulses ready.
- Registers the read data and returns a one-cycle completion to the winning port.
- Sits between the MEM stage and the SRAM controller in the Mem-stage directory.

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/sram_access_arbiter_pick.sv | 27 ++
 rtl/sram_access_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM access arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/sram_access_arbiter_pick.sv
// Two-way winner select: fixed priority to port 0, or round-robin against last grant.
module arb_pick2
  import sram_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_o
);

  // Tie goes to port 0 (fixed) or to the port that did not win last time.
  always_comb begin
    grant_o = PORT_DATA;
    if (req0_i && req1_i) begin
      if (FIXED_PRIO != 0) begin
        grant_o = PORT_DATA;
      end else begin
        grant_o = ~last_grant_i;
      end
    end else if (req1_i) begin
      grant_o = PORT_AUX;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one SRAM controller word interface between the MEM-stage port and an aux master.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_rd_en,
  input  logic              p0_wr_en,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ready,
  input  logic              p1_rd_en,
  input  logic              p1_wr_en,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ready,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              grant_id
);

  state_e              state_q;
  logic                last_grant_q;
  logic                grant_id_q;
  logic                op_q;
  logic                mem_rd_en_q;
  logic                mem_wr_en_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                req0_c;
  logic                req1_c;
  logic                win_c;
  logic                win_op_c;
  logic [ADDR_W-1:0]   win_addr_c;
  logic [DATA_W-1:0]   win_wdata_c;

  assign req0_c = p0_rd_en | p0_wr_en;
  assign req1_c = p1_rd_en | p1_wr_en;

  arb_pick2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .req0_i       (req0_c),
    .req1_i       (req1_c),
    .last_grant_i (last_grant_q),
    .grant_o      (win_c)
  );

  // Mux the winning port's command; a simultaneous rd+wr is treated as a write.
  always_comb begin
    win_op_c    = p0_wr_en ? OP_WR : OP_RD;
    win_addr_c  = p0_addr;
    win_wdata_c = p0_wdata;
    if (win_c == PORT_AUX) begin
      win_op_c    = p1_wr_en ? OP_WR : OP_RD;
      win_addr_c  = p1_addr;
      win_wdata_c = p1_wdata;
    end
  end

  // Arbitration FSM with latched command and read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_AUX;
      grant_id_q   <= PORT_DATA;
      op_q         <= OP_RD;
      mem_rd_en_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mem_rd_en_q <= 1'b0;
          mem_wr_en_q <= 1'b0;
          if (req0_c || req1_c) begin
            grant_id_q   <= win_c;
            last_grant_q <= win_c;
            op_q         <= win_op_c;
            addr_q       <= win_addr_c;
            wdata_q      <= win_wdata_c;
            mem_rd_en_q  <= (win_op_c == OP_RD);
            mem_wr_en_q  <= (win_op_c == OP_WR);
            state_q      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            if (op_q == OP_RD) begin
              rdata_q <= mem_rdata;
            end
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          mem_rd_en_q <= 1'b0;
          mem_wr_en_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = grant_id_q;
  assign p0_rdata  = rdata_q;
  assign p1_rdata  = rdata_q;

  // Idle ports never stall; a requester gets one ready cycle in RESP.
  assign p0_ready = ~req0_c | ((state_q == ST_RESP) && (grant_id_q == PORT_DATA));
  assign p1_ready = ~req1_c | ((state_q == ST_RESP) && (grant_id_q == PORT_AUX));

endmodule
